// File: rtl/regfile_scoreboard.sv
// Register-file busy-bit scoreboard: tracks pending writes per register and
// decides issue/stall for RAW and WAW hazards with same-cycle writeback bypass.
module regfile_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   issue_valid_i,
    input  logic [ADDR_W-1:0]      issue_dst_i,
    input  logic                   issue_dst_used_i,
    input  logic [ADDR_W-1:0]      src_a_i,
    input  logic [ADDR_W-1:0]      src_b_i,
    input  logic                   src_a_used_i,
    input  logic                   src_b_used_i,
    output logic                   issue_ready_o,
    output logic                   stall_o,
    input  logic                   wb_valid_i,
    input  logic [ADDR_W-1:0]      wb_dst_i,
    input  logic                   flush_i,
    output logic [2**ADDR_W-1:0]   busy_o,
    output logic [2**ADDR_W-1:0]   dst_onehot_o,
    output logic [ADDR_W:0]        pending_count_o
);

    localparam int NUM_REGS = 2**ADDR_W;
    localparam int CNT_W    = ADDR_W + 1;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] dst_oh_q, dst_oh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REGS-1:0] wb_dec, ebusy, set_vec, clr_vec;
    logic                raw_a, raw_b, waw, fire;

    // One-hot decode; a hardwired zero register never appears in any decode.
    function automatic logic [NUM_REGS-1:0] dec(input logic [ADDR_W-1:0] x);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[x] = 1'b1;
        if (ZERO_REG) v[0] = 1'b0;
        return v;
    endfunction

    always_comb begin
        wb_dec        = wb_valid_i ? dec(wb_dst_i) : '0;
        ebusy         = busy_q & ~wb_dec;
        raw_a         = src_a_used_i & ebusy[src_a_i];
        raw_b         = src_b_used_i & ebusy[src_b_i];
        waw           = issue_dst_used_i & ebusy[issue_dst_i];
        issue_ready_o = ~flush_i & ~raw_a & ~raw_b & ~waw;
        stall_o       = issue_valid_i & ~issue_ready_o;
        fire          = issue_valid_i & issue_ready_o;
        set_vec       = (fire & issue_dst_used_i) ? dec(issue_dst_i) : '0;
        clr_vec       = wb_dec & busy_q;

        if (flush_i) begin
            busy_d   = '0;
            dst_oh_d = '0;
            cnt_d    = '0;
        end else begin
            // Set is applied after clear so a same-index issue keeps the bit.
            busy_d   = (busy_q & ~clr_vec) | set_vec;
            dst_oh_d = set_vec;
            cnt_d    = cnt_q + {{ADDR_W{1'b0}}, |set_vec} - {{ADDR_W{1'b0}}, |clr_vec};
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_q   <= '0;
            dst_oh_q <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            dst_oh_q <= dst_oh_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy_o          = busy_q;
    assign dst_onehot_o    = dst_oh_q;
    assign pending_count_o = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a 32-entry instance with a hardwired
// zero register and an 8-entry instance without one.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 32-entry instance (ADDR_W=5, ZERO_REG=1)
    logic        a_rst_n, a_iv, a_du, a_sau, a_sbu, a_wbv, a_fl;
    logic [4:0]  a_dst, a_sa, a_sb, a_wbd;
    logic        a_rdy, a_stall;
    logic [31:0] a_busy, a_oh;
    logic [5:0]  a_cnt;

    // 8-entry instance (ADDR_W=3, ZERO_REG=0)
    logic        b_rst_n, b_iv, b_du, b_sau, b_sbu, b_wbv, b_fl;
    logic [2:0]  b_dst, b_sa, b_sb, b_wbd;
    logic        b_rdy, b_stall;
    logic [7:0]  b_busy, b_oh;
    logic [3:0]  b_cnt;

    regfile_scoreboard #(.ADDR_W(5), .ZERO_REG(1'b1)) u_dut_a (
        .clock_i(clk), .reset_n_i(a_rst_n),
        .issue_valid_i(a_iv), .issue_dst_i(a_dst), .issue_dst_used_i(a_du),
        .src_a_i(a_sa), .src_b_i(a_sb), .src_a_used_i(a_sau), .src_b_used_i(a_sbu),
        .issue_ready_o(a_rdy), .stall_o(a_stall),
        .wb_valid_i(a_wbv), .wb_dst_i(a_wbd), .flush_i(a_fl),
        .busy_o(a_busy), .dst_onehot_o(a_oh), .pending_count_o(a_cnt)
    );

    regfile_scoreboard #(.ADDR_W(3), .ZERO_REG(1'b0)) u_dut_b (
        .clock_i(clk), .reset_n_i(b_rst_n),
        .issue_valid_i(b_iv), .issue_dst_i(b_dst), .issue_dst_used_i(b_du),
        .src_a_i(b_sa), .src_b_i(b_sb), .src_a_used_i(b_sau), .src_b_used_i(b_sbu),
        .issue_ready_o(b_rdy), .stall_o(b_stall),
        .wb_valid_i(b_wbv), .wb_dst_i(b_wbd), .flush_i(b_fl),
        .busy_o(b_busy), .dst_onehot_o(b_oh), .pending_count_o(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_iv = 0; a_du = 0; a_dst = 0; a_sa = 0; a_sb = 0; a_sau = 0; a_sbu = 0;
        a_wbv = 0; a_wbd = 0; a_fl = 0;
    endtask

    task automatic b_idle();
        b_iv = 0; b_du = 0; b_dst = 0; b_sa = 0; b_sb = 0; b_sau = 0; b_sbu = 0;
        b_wbv = 0; b_wbd = 0; b_fl = 0;
    endtask

    logic [4:0] flush_regs [8] = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd12, 5'd13, 5'd14, 5'd15};

    initial begin
        a_idle(); b_idle();
        a_rst_n = 0; b_rst_n = 0;
        #2;
        check("rst_busy", a_busy, 32'h0);
        check("rst_onehot", a_oh, 32'h0);
        check("rst_count", a_cnt, 6'd0);
        check("rst_ready", a_rdy, 1'b1);
        check("rst_b_count", b_cnt, 4'd0);

        // Single issue to r7
        @(negedge clk);
        a_rst_n = 1; b_rst_n = 1;
        a_iv = 1; a_du = 1; a_dst = 5'd7;
        #1;
        check("issue7_ready", a_rdy, 1'b1);
        check("issue7_stall", a_stall, 1'b0);
        tick();
        a_idle();
        check("issue7_busy", a_busy, 32'h0000_0080);
        check("issue7_onehot", a_oh, 32'h80);
        check("issue7_count", a_cnt, 6'd1);
        tick();
        check("issue7_onehot_clr", a_oh, 32'h0);
        check("issue7_busy_hold", a_busy, 32'h0000_0080);

        // RAW on r7: stall, then release through writeback bypass
        a_iv = 1; a_sa = 5'd7; a_sau = 1;
        #1;
        check("raw_stall", a_stall, 1'b1);
        check("raw_ready", a_rdy, 1'b0);
        tick();
        check("raw_nofire_onehot", a_oh, 32'h0);
        check("raw_nofire_count", a_cnt, 6'd1);
        a_wbv = 1; a_wbd = 5'd7; a_du = 1; a_dst = 5'd9;
        #1;
        check("raw_bypass_ready", a_rdy, 1'b1);
        check("raw_bypass_stall", a_stall, 1'b0);
        tick();
        a_idle();
        check("raw_release_busy", a_busy, 32'h0000_0200);
        check("raw_release_onehot", a_oh, 32'h200);
        check("raw_release_count", a_cnt, 6'd1);

        // WAW on r3 with same-cycle writeback
        a_iv = 1; a_du = 1; a_dst = 5'd3;
        tick();
        check("waw_setup_busy", a_busy, 32'h0000_0208);
        check("waw_setup_count", a_cnt, 6'd2);
        a_wbv = 1; a_wbd = 5'd3;
        #1;
        check("waw_wb_ready", a_rdy, 1'b1);
        tick();
        a_idle();
        check("waw_wb_busy", a_busy, 32'h0000_0208);
        check("waw_wb_count", a_cnt, 6'd2);
        check("waw_wb_onehot", a_oh, 32'h8);
        a_iv = 1; a_du = 1; a_dst = 5'd9;
        #1;
        check("waw_stall", a_stall, 1'b1);
        tick();
        a_idle();
        check("waw_nofire_onehot", a_oh, 32'h0);
        check("waw_nofire_busy", a_busy, 32'h0000_0208);

        // Zero register as destination and source; stray writeback to r5
        a_iv = 1; a_du = 1; a_dst = 5'd0; a_sb = 5'd0; a_sbu = 1;
        a_wbv = 1; a_wbd = 5'd5;
        #1;
        check("zero_ready", a_rdy, 1'b1);
        tick();
        a_idle();
        check("zero_busy", a_busy, 32'h0000_0208);
        check("zero_count", a_cnt, 6'd2);
        check("zero_onehot", a_oh, 32'h0);

        // Flush priority
        a_fl = 1;
        tick();
        a_idle();
        check("flush1_busy", a_busy, 32'h0);
        check("flush1_count", a_cnt, 6'd0);
        for (int i = 0; i < 8; i++) begin
            a_iv = 1; a_du = 1; a_dst = flush_regs[i];
            tick();
        end
        a_idle();
        check("fill_busy", a_busy, 32'h0000_F0F0);
        check("fill_count", a_cnt, 6'd8);
        check("fill_onehot", a_oh, 32'h8000);
        a_fl = 1; a_iv = 1; a_du = 1; a_dst = 5'd1;
        #1;
        check("flush2_ready", a_rdy, 1'b0);
        check("flush2_stall", a_stall, 1'b1);
        tick();
        a_idle();
        check("flush2_busy", a_busy, 32'h0);
        check("flush2_count", a_cnt, 6'd0);
        check("flush2_onehot", a_oh, 32'h0);

        // 8-entry instance: fill every register, stray writeback first
        for (int i = 0; i < 8; i++) begin
            b_iv = 1; b_du = 1; b_dst = 3'(i);
            b_wbv = (i == 0); b_wbd = 3'd5;
            tick();
            if (i == 0) begin
                check("b_stray_count", b_cnt, 4'd1);
                check("b_stray_busy", b_busy, 8'h01);
            end
        end
        b_idle();
        check("b_full_busy", b_busy, 8'hFF);
        check("b_full_count", b_cnt, 4'd8);
        check("b_full_onehot", b_oh, 8'h80);
        b_iv = 1; b_sa = 3'd2; b_sau = 1;
        #1;
        check("b_full_stall", b_stall, 1'b1);
        #1;
        b_rst_n = 0;
        #1;
        check("b_async_busy", b_busy, 8'h0);
        check("b_async_count", b_cnt, 4'd0);
        check("b_async_onehot", b_oh, 8'h0);
        b_idle();
        @(negedge clk);
        b_rst_n = 1;
        b_iv = 1; b_du = 1; b_dst = 3'd3;
        tick();
        b_idle();
        check("b_post_busy", b_busy, 8'h08);
        check("b_post_count", b_cnt, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register-file busy-bit scoreboard for the pipelined MIPS datapath: generalises the fixed 5-to-32 one-hot decoder into an N-entry tracker. Destination and writeback indices are decoded to one-hot internally. Pending writes are recorded per register. The block produces an issue-ready/stall decision for RAW and WAW hazards, with same-cycle writeback bypass, flush and a pending-write counter. It sits between decode and issue; writeback drives the clear port.

## Interface
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W (derived, not overridable)
- ZERO_REG, 1, when 1 register 0 is hardwired: never set busy, never a hazard source
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode presents an instruction
- issue_dst  in  ADDR_W  destination register of the instruction
- issue_dst_used  in  1  instruction writes a register
- src_a, src_b  in  ADDR_W  source registers
- src_a_used, src_b_used  in  1  source is actually read
- issue_ready  out  1  combinational; instruction may issue this cycle
- stall  out  1  combinational; issue_valid & ~issue_ready
- wb_valid  in  1  writeback completes this cycle
- wb_dst  in  ADDR_W  register being written back
- flush  in  1  synchronous clear of all pending state
- busy  out  NUM_REGS  registered busy vector, bit i = write to reg i pending
- dst_onehot  out  NUM_REGS  registered one-hot of the destination accepted last cycle, else 0
- pending_count  out  ADDR_W+1  registered number of set busy bits

## Operation
- Decode: dec(x) = one-hot of x over NUM_REGS. With ZERO_REG=1, bit 0 of every decode is masked to 0.
- Effective busy: ebusy = busy & ~(wb_valid ? dec(wb_dst) : 0). A same-cycle writeback counts as already complete.
- raw_a = src_a_used & ebusy[src_a]; raw_b likewise.
- waw = issue_dst_used & ebusy[issue_dst].
- issue_ready = ~flush & ~raw_a & ~raw_b & ~waw.
- fire = issue_valid & issue_ready.
- set = fire & issue_dst_used & dec(issue_dst) (zero vector if masked).
- clr = wb_valid & dec(wb_dst) & busy. A writeback to a non-busy register is ignored.
- busy_next = (busy & ~clr) | set. Set wins over clear on the same index.
- pending_count_next = pending_count + |set − |clr. It never wraps, since WAW blocks a set on an index that is already busy and not cleared.
- dst_onehot_next = set.
- Flush has priority over issue and writeback: busy, dst_onehot and pending_count all go to 0, and issue_ready is 0 while flush=1.
- Reset (asynchronous assert, reset_n=0): busy=0, dst_onehot=0, pending_count=0. issue_ready is then 1 unless flush or a used source/destination hazard exists, which cannot happen with busy=0.

## Timing
- Issue decision: zero latency. issue_ready/stall depend combinationally on the current busy, wb_* and issue_*.
- Issue accepted in cycle N: busy[d]=1, dst_onehot=dec(d) and count+1 are all visible in cycle N+1. dst_onehot returns to 0 in N+2 unless another fire occurs.
- Writeback in cycle N: it bypasses hazards in cycle N, and busy[d] clears at edge N→N+1.
- Issue and writeback to the same d in one cycle: the issue is accepted and busy[d] stays 1, with the count unchanged.
- Issue and writeback to different indices: both apply, and the count is unchanged.
- Reset assertion mid-operation clears state immediately, independent of clock. Deassertion is synchronised externally; the first edge after deassertion behaves as a normal cycle.
- All NUM_REGS busy simultaneously (ZERO_REG=0): pending_count = NUM_REGS, which fits in ADDR_W+1 bits.

## Test plan
- Reset then single issue: reset_n low, issue dst=7 valid → next cycle busy=0x00000080, dst_onehot=0x80, pending_count=1. The following cycle dst_onehot=0.
- RAW stall and release: busy[7]=1, issue src_a=7 used → stall=1. In the cycle with wb_valid, wb_dst=7 → issue_ready=1, fire occurs, and busy[7] clears the next cycle.
- WAW with same-cycle writeback: busy[3]=1, issue dst=3 with wb_dst=3 → accepted, busy[3] stays 1, pending_count unchanged.
- Zero register (ZERO_REG=1): issue dst=0 → busy stays 0 and count stays 0. A source src_b=0 is never a hazard.
- Flush priority: busy=0x0000F0F0, count=8, flush=1 with issue dst=1 valid → issue_ready=0, and next cycle busy=0, count=0, dst_onehot=0.
- Parameter sweep ADDR_W=3, ZERO_REG=0: issue all 8 registers over 8 cycles → pending_count=8, busy=0xFF. Stray writeback to a non-busy register is ignored. Async reset mid-sequence clears all state within the same cycle.
